mmu_ws_array: RTL and testbench



---
 rtl/mmu_ws_array.sv | 147 ++++++++++++++
 tb/tb_mmu_ws_array.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_ws_array.sv
// rtl/mmu_ws_array.sv - weight-stationary ROWS x COLS matrix multiply unit
// Double-buffered weights, 3-stage product/sum/accumulate pipeline with valid/ready backpressure.
module mmu_ws_array #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [COLS*DW-1:0]    w_row,
  output logic                  w_loaded,
  input  logic                  w_swap,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ROWS*DW-1:0]    a_data,
  input  logic                  a_signed,
  input  logic                  a_acc,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [COLS*ACC_W-1:0] o_data
);
  localparam int CW = $clog2(ROWS);
  localparam int PW = 2 * DW;
  localparam int XW = ACC_W - PW;

  if (ACC_W < 2 * DW + $clog2(ROWS)) begin : g_acc_w_check
    $error("mmu_ws_array: ACC_W too narrow for ROWS products of DW-bit operands");
  end

  typedef enum logic [1:0] {W_EMPTY, W_LOAD, W_FULL} w_state_t;

  w_state_t              w_state, w_state_nx;
  logic [CW-1:0]         w_cnt;
  logic [COLS*DW-1:0]    shadow [ROWS];
  logic [COLS*DW-1:0]    active [ROWS];
  logic                  active_valid;
  logic                  w_accept, w_last, w_commit;

  logic                  adv, a_accept;
  logic [PW-1:0]         prod_d [ROWS][COLS];
  logic [PW-1:0]         s1_prod [ROWS][COLS];
  logic                  s1_valid, s1_signed, s1_acc;
  logic [ACC_W-1:0]      sum_d [COLS];
  logic [ACC_W-1:0]      s2_sum [COLS];
  logic                  s2_valid, s2_acc;

  // Widening both operands to 2*DW makes the truncated product correct for either signedness.
  function automatic logic [PW-1:0] ext_op(input logic [DW-1:0] v, input logic sgn);
    return {{DW{sgn & v[DW-1]}}, v};
  endfunction

  function automatic logic [ACC_W-1:0] ext_acc(input logic [PW-1:0] p, input logic sgn);
    return {{XW{sgn & p[PW-1]}}, p};
  endfunction

  assign w_accept = w_valid && w_ready;
  assign w_last   = (w_cnt == CW'(ROWS - 1));
  assign w_commit = (w_state == W_FULL) && w_swap;

  always_comb begin
    w_state_nx = w_state;
    w_ready    = (w_state != W_FULL);
    w_loaded   = (w_state == W_FULL);
    case (w_state)
      W_EMPTY: if (w_accept) w_state_nx = w_last ? W_FULL : W_LOAD;
      W_LOAD:  if (w_accept && w_last) w_state_nx = W_FULL;
      W_FULL:  if (w_swap) w_state_nx = W_EMPTY;
      default: w_state_nx = W_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state      <= W_EMPTY;
      w_cnt        <= '0;
      active_valid <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        shadow[r] <= '0;
        active[r] <= '0;
      end
    end else begin
      w_state <= w_state_nx;
      if (w_accept) begin
        shadow[w_cnt] <= w_row;
        w_cnt         <= w_last ? '0 : w_cnt + CW'(1);
      end
      if (w_commit) begin
        for (int r = 0; r < ROWS; r++) active[r] <= shadow[r];
        active_valid <= 1'b1;
        w_cnt        <= '0;
      end
    end
  end

  assign adv      = !o_valid || o_ready;
  assign a_ready  = active_valid && adv;
  assign a_accept = a_valid && a_ready;

  always_comb begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        prod_d[r][c] = ext_op(a_data[r*DW +: DW], a_signed) *
                       ext_op(active[r][c*DW +: DW], a_signed);
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      sum_d[c] = '0;
      for (int r = 0; r < ROWS; r++)
        sum_d[c] = sum_d[c] + ext_acc(s1_prod[r][c], s1_signed);
    end
  end

  // Datapath registers need no reset: they are only consumed under their stage valid.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (a_accept) begin
        s1_prod   <= prod_d;
        s1_signed <= a_signed;
        s1_acc    <= a_acc;
      end
      if (s1_valid) begin
        s2_sum <= sum_d;
        s2_acc <= s1_acc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else if (adv) begin
      s1_valid <= a_accept;
      s2_valid <= s1_valid;
      o_valid  <= s2_valid;
      if (s2_valid)
        for (int c = 0; c < COLS; c++)
          o_data[c*ACC_W +: ACC_W] <= s2_acc ? o_data[c*ACC_W +: ACC_W] + s2_sum[c] : s2_sum[c];
    end
  end
endmodule

// File: tb/tb_mmu_ws_array.sv
// tb/tb_mmu_ws_array.sv - self-checking bench for mmu_ws_array
// Directed vector table, stall/swap sequences and random traffic against a scoreboard model.
module tb_mmu_ws_array;
  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int DW    = 8;
  localparam int ACC_W = 32;
  localparam int OW    = COLS * ACC_W;
  typedef logic [OW-1:0] ovec_t;
  typedef logic [ROWS*DW-1:0] avec_t;

  logic               clk, reset;
  logic               w_valid, w_ready, w_loaded, w_swap;
  logic [COLS*DW-1:0] w_row;
  logic               a_valid, a_ready, a_signed, a_acc;
  avec_t              a_data;
  logic               o_valid, o_ready;
  ovec_t              o_data;

  mmu_ws_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .w_loaded(w_loaded), .w_swap(w_swap),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_signed(a_signed), .a_acc(a_acc),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input ovec_t act, input ovec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: matrices as plain arrays, results as integer dot products.
  logic [DW-1:0]    sh_m [ROWS][COLS];
  logic [DW-1:0]    ac_m [ROWS][COLS];
  int               wcnt_m;
  bit               act_m;
  ovec_t            prev_m;
  ovec_t            sb [$];
  logic [ACC_W-1:0] got_q [$];
  bit               stall_prev;
  ovec_t            held;
  int               n_out = 0;
  int               n_acc = 0;

  task automatic reset_model();
    sb.delete();
    got_q.delete();
    prev_m     = '0;
    wcnt_m     = 0;
    act_m      = 1'b0;
    stall_prev = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        sh_m[r][c] = '0;
        ac_m[r][c] = '0;
      end
  endtask

  function automatic ovec_t model_beat(input avec_t a, input logic sgn, input logic acc, input ovec_t prev);
    ovec_t  e;
    longint s, av, wv;
    e = '0;
    for (int c = 0; c < COLS; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++) begin
        av = sgn ? longint'($signed(a[r*DW +: DW])) : longint'({1'b0, a[r*DW +: DW]});
        wv = sgn ? longint'($signed(ac_m[r][c]))    : longint'({1'b0, ac_m[r][c]});
        s  = s + av * wv;
      end
      e[c*ACC_W +: ACC_W] = acc ? prev[c*ACC_W +: ACC_W] + s[ACC_W-1:0] : s[ACC_W-1:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev) begin
        chkb("hold_valid", o_valid, 1'b1);
        chk("hold_data", o_data, held);
      end
      stall_prev = o_valid && !o_ready;
      held       = o_data;
      chkb("w_ready", w_ready, wcnt_m != ROWS);
      chkb("w_loaded", w_loaded, wcnt_m == ROWS);
      chkb("a_ready", a_ready, act_m && (!o_valid || o_ready));
      if (o_valid && o_ready) begin
        if (sb.size() == 0) chkb("spurious_out", o_valid, 1'b0);
        else chk("out_data", o_data, sb.pop_front());
        got_q.push_back(o_data[ACC_W-1:0]);
        n_out++;
      end
      if (a_valid && a_ready) begin
        prev_m = model_beat(a_data, a_signed, a_acc, prev_m);
        sb.push_back(prev_m);
        n_acc++;
      end
      if (w_valid && w_ready) begin
        for (int c = 0; c < COLS; c++) sh_m[wcnt_m][c] = w_row[c*DW +: DW];
        wcnt_m++;
      end else if (w_swap && wcnt_m == ROWS) begin
        ac_m   = sh_m;
        act_m  = 1'b1;
        wcnt_m = 0;
      end
    end
  end

  // sel: 0 identity, 1 all 0xFF, 2 all 2, 3 random
  function automatic logic [COLS*DW-1:0] wrow(input int sel, input int k);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++)
      case (sel)
        0:       v[c*DW +: DW] = (c == k) ? DW'(1) : DW'(0);
        1:       v[c*DW +: DW] = '1;
        2:       v[c*DW +: DW] = DW'(2);
        default: v[c*DW +: DW] = DW'($urandom);
      endcase
    return v;
  endfunction

  function automatic avec_t fill(input logic [DW-1:0] b);
    avec_t v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = b;
    return v;
  endfunction

  task automatic load_bank(input int sel);
    for (int k = 0; k < ROWS; k++) begin
      w_row   = wrow(sel, k);
      w_valid = 1'b1;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    chkb("loaded", w_loaded, 1'b1);
  endtask

  task automatic do_swap();
    w_swap = 1'b1;
    @(posedge clk); #1;
    w_swap = 1'b0;
    chkb("swap_drop", w_loaded, 1'b0);
  endtask

  task automatic send_beat(input avec_t a, input logic sgn, input logic acc, output ovec_t res, output int lat);
    a_data = a; a_signed = sgn; a_acc = acc; a_valid = 1'b1;
    res = '0; lat = 0;
    for (int i = 0; i < 50 && !a_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!a_ready) begin
      chkb("accept_timeout", a_ready, 1'b1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o_data;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int               wsel;
    logic             ramp;
    logic [DW-1:0]    fill;
    logic             sgn;
    logic             acc;
    logic [ACC_W-1:0] base;
    logic             eramp;
  } vec_t;

  vec_t  tbl [9];
  ovec_t res, expv;
  int    lat, cur_w, sent, n_before, acc_base, k_swap;
  bit    fresh;
  avec_t ramp_v;

  initial begin
    tbl[0] = '{0, 1'b1, 8'h00, 1'b1, 1'b0, 32'd1,          1'b1};
    tbl[1] = '{0, 1'b0, 8'h02, 1'b1, 1'b0, 32'd2,          1'b0};
    tbl[2] = '{0, 1'b0, 8'h02, 1'b1, 1'b1, 32'd4,          1'b0};
    tbl[3] = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 32'd0,          1'b0};
    tbl[4] = '{0, 1'b0, 8'hFF, 1'b1, 1'b0, 32'hFFFF_FFFF,  1'b0};
    tbl[5] = '{0, 1'b0, 8'hFF, 1'b0, 1'b1, 32'd254,        1'b0};
    tbl[6] = '{1, 1'b0, 8'h80, 1'b1, 1'b0, 32'd2048,       1'b0};
    tbl[7] = '{1, 1'b0, 8'h80, 1'b0, 1'b0, 32'd522240,     1'b0};
    tbl[8] = '{2, 1'b0, 8'h01, 1'b0, 1'b0, 32'd32,         1'b0};
    for (int r = 0; r < ROWS; r++) ramp_v[r*DW +: DW] = DW'(r + 1);

    reset = 1'b1; w_valid = 1'b0; w_row = '0; w_swap = 1'b0;
    a_valid = 1'b0; a_data = '0; a_signed = 1'b0; a_acc = 1'b0; o_ready = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_w_ready", w_ready, 1'b1);
    chkb("rst_w_loaded", w_loaded, 1'b0);
    chkb("rst_a_ready", a_ready, 1'b0);
    chkb("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, '0);
    reset = 1'b0;

    // No weights committed: beats must be refused
    a_valid = 1'b1; a_data = fill(8'h01);
    repeat (20) begin
      @(negedge clk);
      chkb("noweights_a_ready", a_ready, 1'b0);
      chkb("noweights_o_valid", o_valid, 1'b0);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    chkb("noweights_w_ready", w_ready, 1'b1);
    chkb("noweights_w_loaded", w_loaded, 1'b0);

    cur_w = -1;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wsel != cur_w) begin
        load_bank(tbl[i].wsel);
        do_swap();
        cur_w = tbl[i].wsel;
      end
      send_beat(tbl[i].ramp ? ramp_v : fill(tbl[i].fill), tbl[i].sgn, tbl[i].acc, res, lat);
      chk_i($sformatf("latency%0d", i), lat, 3);
      for (int c = 0; c < COLS; c++)
        expv[c*ACC_W +: ACC_W] = tbl[i].base + (tbl[i].eramp ? ACC_W'(c) : ACC_W'(0));
      chk($sformatf("vec%0d", i), res, expv);
    end

    // Six back-to-back beats with output stalled on cycles 2..6
    sent = 0; n_before = n_out; fresh = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      o_ready = !(cyc >= 2 && cyc <= 6);
      a_valid = (sent < 6);
      if (fresh) begin
        for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = DW'($urandom);
        a_signed = 1'($urandom); a_acc = 1'($urandom);
      end
      @(negedge clk);
      fresh = a_valid && a_ready;
      if (fresh) sent++;
      if (o_valid && !o_ready) chkb("stall_a_ready", a_ready, 1'b0);
      @(posedge clk); #1;
    end
    o_ready = 1'b1; a_valid = 1'b0;
    chk_i("stream_count", n_out - n_before, 6);
    chk_i("stream_sb_empty", sb.size(), 0);

    // Swap coinciding with an accepted beat; a swap during loading is ignored
    load_bank(0);
    do_swap();
    got_q.delete();
    acc_base = n_acc;
    a_data = fill(8'h01); a_signed = 1'b0; a_acc = 1'b0; a_valid = 1'b1;
    for (int k = 0; k < ROWS; k++) begin
      w_row = wrow(2, k); w_valid = 1'b1; w_swap = (k == 5);
      @(posedge clk); #1;
      if (k == 5) chkb("swap_in_load_ignored", w_loaded, 1'b0);
    end
    w_valid = 1'b0; w_swap = 1'b0;
    chkb("t6_loaded", w_loaded, 1'b1);
    k_swap = n_acc - acc_base;
    w_swap = 1'b1;
    @(posedge clk); #1;
    w_swap = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    a_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chkb("t6_count", got_q.size() > k_swap + 1, 1'b1);
    if (got_q.size() > k_swap + 1) begin
      chk_i("t6_swap_beat_old", int'(got_q[k_swap]), 1);
      chk_i("t6_next_beat_new", int'(got_q[k_swap+1]), 32);
    end

    // Random concurrent traffic with backpressure, loads and swaps
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_valid = ($urandom_range(3) != 0);
      for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = DW'($urandom);
      a_signed = 1'($urandom); a_acc = 1'($urandom);
      o_ready  = ($urandom_range(2) != 0);
      w_valid  = 1'($urandom);
      w_row    = wrow(3, 0);
      w_swap   = ($urandom_range(7) == 0);
      @(posedge clk); #1;
    end
    a_valid = 1'b0; w_valid = 1'b0; w_swap = 1'b0; o_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk_i("random_drain", sb.size(), 0);

    // Reset with traffic in flight, then accumulate onto a cleared result
    a_data = fill(8'h05); a_acc = 1'b0; a_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    reset_model();
    #1;
    chkb("midrst_o_valid", o_valid, 1'b0);
    chkb("midrst_a_ready", a_ready, 1'b0);
    chkb("midrst_w_loaded", w_loaded, 1'b0);
    chk("midrst_o_data", o_data, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chkb("postrst_a_ready", a_ready, 1'b0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    load_bank(0);
    do_swap();
    send_beat(fill(8'h03), 1'b0, 1'b1, res, lat);
    chk("postrst_acc_from_zero", res, {COLS{32'd3}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
